// File: rtl/link_rx_buffer.sv
// Link receive buffer: show-ahead FIFO between the link receiver and a switch
// inject port, with credit return, sticky overflow and a per-window
// utilisation counter.
module link_rx_buffer #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned Depth     = 16,
    parameter int unsigned PtrWidth  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] rx_data,
    input  logic                 rx_ready,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_slot_avail,
    output logic                 credit_return,
    output logic [PtrWidth:0]    occupancy,
    output logic                 overflow,
    output logic [7:0]           inject_util
);

    logic [DataWidth-1:0] mem [Depth];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrWidth:0]   occ_q, occ_d;
    logic                overflow_q, overflow_d;
    logic                credit_q, credit_d;
    logic [7:0]          win_q, win_d;
    logic [7:0]          acc_q, acc_d;
    logic [7:0]          util_q, util_d;
    logic [7:0]          acc_sum;

    logic full;
    logic wr_evt;
    logic rd_evt;
    logic wr_acc;

    assign full   = (occ_q == (PtrWidth + 1)'(Depth));
    assign wr_evt = rx_data[DataWidth-1] && rx_ready;
    assign rd_evt = out_valid && out_slot_avail;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_acc = wr_evt && (!full || rd_evt);

    // Outputs are derived from registered state only.
    assign out_data      = mem[rd_ptr_q];
    assign out_valid     = (occ_q != '0);
    assign occupancy     = occ_q;
    assign overflow      = overflow_q;
    assign credit_return = credit_q;
    assign inject_util   = util_q;

    // Next-state for pointers, occupancy, flags and utilisation counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        credit_d   = rd_evt;
        win_d      = win_q + 8'd1;
        acc_d      = acc_q;
        util_d     = util_q;
        acc_sum    = acc_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        if (rd_evt) rd_ptr_d = rd_ptr_q + PtrWidth'(1);

        case ({wr_acc, rd_evt})
            2'b10:   occ_d = occ_q + (PtrWidth + 1)'(1);
            2'b01:   occ_d = occ_q - (PtrWidth + 1)'(1);
            default: occ_d = occ_q;
        endcase

        if (wr_evt && full && !rd_evt) overflow_d = 1'b1;

        if (wr_acc && (acc_q != 8'hFF)) acc_sum = acc_q + 8'd1;

        // Window end: publish the count including this cycle's write, restart.
        if (win_q == 8'hFF) begin
            util_d = acc_sum;
            acc_d  = '0;
        end else begin
            acc_d  = acc_sum;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            credit_q   <= 1'b0;
            win_q      <= '0;
            acc_q      <= '0;
            util_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            credit_q   <= credit_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            util_q     <= util_d;
        end
    end

    // Flit storage; not cleared by reset, writes in the reset cycle dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_link_rx_buffer.sv
// Self-checking bench for link_rx_buffer: vector table plus scoreboarded
// sequences for fill/overflow, full write+read, reset and utilisation.
module tb_link_rx_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_slot_avail;
    logic          credit_return;
    logic [PW:0]   occupancy;
    logic          overflow;
    logic [7:0]    inject_util;

    link_rx_buffer #(
        .DataWidth(DW),
        .Depth(DEPTH),
        .PtrWidth(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_slot_avail(out_slot_avail),
        .credit_return(credit_return),
        .occupancy(occupancy),
        .overflow(overflow),
        .inject_util(inject_util)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    int            m_occ;
    logic          m_ovf;
    logic          m_credit;
    int            m_win;
    int            m_acc;
    int            m_util;
    int            credit_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          rdy;
        logic          avail;
        int            exp_occ;
        logic          exp_valid;
        logic          exp_credit;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare outputs with the model, apply one cycle of stimulus, advance model.
    task automatic drive(input logic [DW-1:0] d, input logic rdy, input logic av,
                         input logic r);
        logic rd;
        logic wr;
        logic acc;
        chk("occupancy", DW'(occupancy), DW'(m_occ));
        chk("out_valid", DW'(out_valid), DW'(m_occ != 0));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("credit_return", DW'(credit_return), DW'(m_credit));
        chk("inject_util", DW'(inject_util), DW'(m_util));
        if (m_occ != 0) chk("out_data", out_data, q[0]);
        if (credit_return === 1'b1) credit_cnt++;

        rx_data        = d;
        rx_ready       = rdy;
        out_slot_avail = av;
        rst            = r;

        rd  = (m_occ != 0) && av;
        wr  = d[DW-1] && rdy;
        acc = wr && ((m_occ < DEPTH) || rd);
        if (r) begin
            q.delete();
            m_occ = 0; m_ovf = 1'b0; m_credit = 1'b0;
            m_win = 0; m_acc = 0; m_util = 0;
        end else begin
            m_credit = rd;
            if (rd) void'(q.pop_front());
            if (acc) q.push_back(d);
            if (wr && !acc) m_ovf = 1'b1;
            m_occ = q.size();
            if (acc && m_acc < 255) m_acc++;
            if (m_win == 255) begin
                m_util = m_acc;
                m_acc  = 0;
                m_win  = 0;
            end else begin
                m_win++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic av);
        drive('0, 1'b0, av, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_ready = 1'b0; out_slot_avail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_occ = 0; m_ovf = 1'b0; m_credit = 1'b0;
        m_win = 0; m_acc = 0; m_util = 0; credit_cnt = 0;
        rst = 1'b0;

        // Single flit, then gating cases with explicit expectations.
        vecs[0] = '{32'h8000_0001, 1'b1, 1'b0, 1, 1'b1, 1'b0, 32'h8000_0001};
        vecs[1] = '{32'h0000_0000, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h8000_0001};
        vecs[2] = '{32'h0000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{32'h8000_0002, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_0003, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{32'h0000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].data, vecs[i].rdy, vecs[i].avail, 1'b0);
            chk($sformatf("vec%0d occupancy", i), DW'(occupancy), DW'(vecs[i].exp_occ));
            chk($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].exp_valid));
            chk($sformatf("vec%0d credit", i), DW'(credit_return), DW'(vecs[i].exp_credit));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
        end

        // Fill with 17 writes: 17th dropped, overflow sticky.
        for (int i = 0; i < 17; i++) drive(32'h8000_0100 + DW'(i), 1'b1, 1'b0, 1'b0);
        chk("fill occupancy", DW'(occupancy), DW'(16));
        chk("fill overflow", DW'(overflow), DW'(1));
        credit_cnt = 0;
        for (int i = 0; i < 18; i++) idle(1'b1);
        chk("drain credit pulses", DW'(credit_cnt), DW'(16));
        chk("drain occupancy", DW'(occupancy), DW'(0));
        chk("overflow sticky", DW'(overflow), DW'(1));

        // Reset mid-operation with 5 flits buffered; reset-cycle write/read ignored.
        for (int i = 0; i < 5; i++) drive(32'h8000_0200 + DW'(i), 1'b1, 1'b0, 1'b0);
        chk("pre-reset occupancy", DW'(occupancy), DW'(5));
        drive(32'h8000_02FF, 1'b1, 1'b1, 1'b1);
        chk("reset occupancy", DW'(occupancy), DW'(0));
        chk("reset out_valid", DW'(out_valid), DW'(0));
        chk("reset overflow", DW'(overflow), DW'(0));
        chk("reset credit", DW'(credit_return), DW'(0));
        credit_cnt = 0;
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("no credits after reset", DW'(credit_cnt), DW'(0));

        // Full with simultaneous write and read.
        for (int i = 0; i < 16; i++) drive(32'h8000_0300 + DW'(i), 1'b1, 1'b0, 1'b0);
        chk("full occupancy", DW'(occupancy), DW'(16));
        drive(32'h8000_03AA, 1'b1, 1'b1, 1'b0);
        chk("full w+r occupancy", DW'(occupancy), DW'(16));
        chk("full w+r overflow", DW'(overflow), DW'(0));
        chk("full w+r new head", out_data, 32'h8000_0301);
        for (int i = 0; i < 17; i++) idle(1'b1);
        chk("full w+r drained", DW'(occupancy), DW'(0));

        // Utilisation: 40 writes in one window, then a saturating window.
        drive('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive(32'h8000_0400 + DW'(i), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 216; i++) idle(1'b1);
        chk("util 40", DW'(inject_util), DW'(40));
        for (int i = 0; i < 256; i++) drive(32'h8000_0500 + DW'(i), 1'b1, 1'b1, 1'b0);
        chk("util saturated", DW'(inject_util), DW'(255));
        for (int i = 0; i < 44; i++) drive(32'h8000_0600 + DW'(i), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("util stream drained", DW'(occupancy), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/link_rx_buffer.md
LINK_RX_BUFFER -- requirements
Module: link_rx_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 256, flit width; bit DataWidth-1 is the valid bit.
REQ-002 SHALL have parameter Depth, default 16, FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter PtrWidth, default 4, log2(Depth).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have port rx_data, input, DataWidth, parallel flit from link receiver; MSB = valid.
REQ-007 SHALL have port rx_ready, input, 1, link receiver aligned/up.
REQ-008 SHALL have port out_data, output, DataWidth, head-of-FIFO flit to switch inject port.
REQ-009 SHALL have port out_valid, output, 1, head flit present (inject_receive to switch).
REQ-010 SHALL have port out_slot_avail, input, 1, switch inject slot free (InjectSlotAvail).
REQ-011 SHALL have port credit_return, output, 1, one-cycle pulse per flit dequeued.
REQ-012 SHALL have port occupancy, output, PtrWidth+1, current entry count.
REQ-013 SHALL have port overflow, output, 1, sticky flag: flit dropped because FIFO was full.
REQ-014 SHALL have port inject_util, output, 8, accepted-flit count of the last 256-cycle window.

Function
REQ-015 Write event SHALL be rx_data[DataWidth-1] && rx_ready; flits with either term low SHALL be ignored.
REQ-016 Write SHALL store all DataWidth bits at wr_ptr; wr_ptr SHALL increment modulo Depth.
REQ-017 Read event SHALL be out_valid && out_slot_avail; rd_ptr SHALL increment modulo Depth.
REQ-018 FIFO SHALL be show-ahead: out_data = entry[rd_ptr], out_valid = (occupancy != 0), both registered-state derived, no combinational path from rx_data.
REQ-019 Write-to-out_valid latency SHALL be exactly 1 cycle when empty; no write-through bypass.
REQ-020 occupancy SHALL be +1 on write only, -1 on read only, unchanged on simultaneous write+read.
REQ-021 When full (occupancy==Depth) and write without read: flit SHALL be dropped, pointers/occupancy unchanged, overflow set to 1.
REQ-022 When full with simultaneous write and read: write SHALL be accepted, occupancy stays Depth, overflow unchanged.
REQ-023 When empty, out_slot_avail SHALL have no effect; rd_ptr and credit_return unchanged.
REQ-024 credit_return SHALL pulse high for exactly 1 cycle, the cycle after each read event; back-to-back reads give a continuous high.
REQ-025 overflow SHALL remain 1 until rst.
REQ-026 Window counter SHALL count 0..255 cycles and wrap; accept counter SHALL count writes accepted per REQ-016/022, saturating at 255.
REQ-027 On window counter wrap 255->0: inject_util SHALL load accept counter (including a write in that cycle), accept counter SHALL clear.
REQ-028 out_data when out_valid=0 SHALL be don't-care; the valid bit of out_data SHALL NOT be relied on by the consumer.

Reset
REQ-029 rst SHALL clear wr_ptr, rd_ptr, occupancy, overflow, inject_util, window and accept counters, credit_return to 0 on the next rising edge.
REQ-030 rst asserted mid-operation SHALL discard all buffered flits; no credit_return pulse SHALL be emitted for discarded flits.
REQ-031 Writes and reads presented in the reset cycle SHALL be ignored; FIFO storage need not be cleared.

Verification
REQ-032 Single flit: empty, write 0x8..01 with rx_ready=1, out_slot_avail=0 -> next cycle out_valid=1, occupancy=1, out_data=flit; assert out_slot_avail -> following cycle occupancy=0, credit_return=1 for 1 cycle.
REQ-033 Fill/overflow (Depth=16): 17 consecutive writes, out_slot_avail=0 -> occupancy=16, overflow=1, 16 flits drained in order, 17th absent, 16 credit pulses.
REQ-034 Full with simultaneous write+read: occupancy=16, write and read same cycle -> occupancy=16, overflow=0, new flit appears last in order.
REQ-035 Gating: valid bit=1 with rx_ready=0, and valid bit=0 with rx_ready=1 -> occupancy stays 0, inject_util unaffected.
REQ-036 Utilisation: 40 accepted writes within one 256-cycle window -> inject_util=40 from the cycle after wrap; next window with 300 attempted writes and continuous reads -> inject_util=255.
REQ-037 Reset mid-operation: occupancy=5, assert rst 1 cycle -> occupancy=0, out_valid=0, overflow=0, credit_return=0, no pulses for the 5 flits.
